// File: rtl/conv_window_buffer_if.sv
// Stream bundle for conv_window_buffer: row-word write stream in, N_ROW x N_LANE window stream out.
interface conv_window_buffer_if #(
  parameter int N_ROW   = 3,
  parameter int N_LANE  = 4,
  parameter int B_PIXEL = 16
) ();
  logic                            wr_valid;
  logic                            wr_ready;
  logic [N_LANE*B_PIXEL-1:0]       wr_data;
  logic                            rd_valid;
  logic                            rd_ready;
  logic [N_LANE*N_ROW*B_PIXEL-1:0] rd_data;
  logic                            rd_last;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/conv_window_buffer.sv
// Circular row-buffer that turns a raster stream of row words into vertical N_ROW-tall windows.
// Optional macro CONV_WIN_ERR_EN enables the sticky configuration-error flag on err.
module conv_window_buffer #(
  parameter int N_BUF   = 5,
  parameter int N_ROW   = 3,
  parameter int N_LANE  = 4,
  parameter int B_PIXEL = 16,
  parameter int B_ADDR  = 9
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       para_we,
  input  logic [31:0]                para_di,
  output logic                       busy,
  output logic                       err,
  conv_window_buffer_if.slave        bus
);

  localparam int W     = N_LANE * B_PIXEL;
  localparam int WIN_W = W * N_ROW;
  localparam int DEPTH = 1 << B_ADDR;
  localparam int SEL_W = $clog2(N_BUF);

  localparam logic [15:0]      N_ROW_16 = 16'(N_ROW);
  localparam logic [15:0]      N_BUF_16 = 16'(N_BUF);
  localparam logic [16:0]      DEPTH_17 = 17'(DEPTH);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_BUF - 1);

  typedef enum logic [1:0] {IDLE, CONFIG, RUN} state_t;

  state_t             state;
  logic [15:0]        len;
  logic [15:0]        rows;
  logic [B_ADDR-1:0]  last_col;
  logic [15:0]        rows_written;
  logic [15:0]        rows_retired;
  logic [B_ADDR-1:0]  wr_col;
  logic [B_ADDR-1:0]  rd_col;
  logic [SEL_W-1:0]   wr_sel;
  logic [SEL_W-1:0]   rd_base;

  logic               s1_valid;
  logic               s1_last;
  logic [W-1:0]       s1_row [N_ROW];

  logic               rd_valid_q;
  logic               rd_last_q;
  logic [WIN_W-1:0]   rd_data_q;

  logic [15:0]        occupancy;
  logic               wr_fire;
  logic               out_free;
  logic               issue;
  logic               col_end;
  logic               param_bad;
  logic [SEL_W-1:0]   rd_sel [N_ROW];
  logic [WIN_W-1:0]   win_word;

  logic [W-1:0]       mem [N_BUF][DEPTH];

  assign occupancy    = rows_written - rows_retired;
  assign bus.wr_ready = (state == RUN) && (rows_written < rows) && (occupancy < N_BUF_16);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign out_free     = !rd_valid_q || bus.rd_ready;
  assign issue        = (state == RUN) && (occupancy >= N_ROW_16) && (!s1_valid || out_free);
  assign col_end      = (rd_col == last_col);
  assign param_bad    = (len == 16'd0) || ({1'b0, len} > DEPTH_17) || (rows < N_ROW_16);
  assign busy         = (state != IDLE);

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_data_q;

  always_comb begin
    for (int k = 0; k < N_ROW; k++) begin
      rd_sel[k] = SEL_W'((32'(rd_base) + 32'(k)) % 32'(N_BUF));
    end
  end

  // Oldest row of the window lands in the most significant slot of each lane.
  always_comb begin
    win_word = '0;
    for (int j = 0; j < N_LANE; j++) begin
      for (int k = 0; k < N_ROW; k++) begin
        win_word[(j*N_ROW + (N_ROW-1-k))*B_PIXEL +: B_PIXEL] = s1_row[k][j*B_PIXEL +: B_PIXEL];
      end
    end
  end

  // Row storage plus its registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_sel][wr_col] <= bus.wr_data;
    end
    if (issue) begin
      for (int k = 0; k < N_ROW; k++) begin
        s1_row[k] <= mem[rd_sel[k]][rd_col];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      len          <= '0;
      rows         <= '0;
      last_col     <= '0;
      rows_written <= '0;
      rows_retired <= '0;
      wr_col       <= '0;
      rd_col       <= '0;
      wr_sel       <= '0;
      rd_base      <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (para_we) begin
            len   <= para_di[15:0];
            rows  <= para_di[31:16];
            state <= CONFIG;
          end
        end
        CONFIG: begin
          last_col     <= B_ADDR'(len - 16'd1);
          rows_written <= '0;
          rows_retired <= '0;
          wr_col       <= '0;
          rd_col       <= '0;
          wr_sel       <= '0;
          rd_base      <= '0;
          state        <= param_bad ? IDLE : RUN;
        end
        RUN: begin
          if (rd_valid_q && bus.rd_ready && rd_last_q) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_fire) begin
        if (wr_col == last_col) begin
          wr_col       <= '0;
          wr_sel       <= (wr_sel == SEL_MAX) ? '0 : wr_sel + 1'b1;
          rows_written <= rows_written + 16'd1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end

      // A row is retired once its last column has been read out of the RAM.
      if (issue) begin
        s1_valid <= 1'b1;
        s1_last  <= col_end && (rows_retired == rows - N_ROW_16);
        if (col_end) begin
          rd_col       <= '0;
          rd_base      <= (rd_base == SEL_MAX) ? '0 : rd_base + 1'b1;
          rows_retired <= rows_retired + 16'd1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end else if (s1_valid && out_free) begin
        s1_valid <= 1'b0;
        s1_last  <= 1'b0;
      end

      if (out_free) begin
        rd_valid_q <= s1_valid;
        rd_last_q  <= s1_valid && s1_last;
        if (s1_valid) begin
          rd_data_q <= win_word;
        end
      end
    end
  end

`ifdef CONV_WIN_ERR_EN
  logic err_q;

  // Sticky until a legal configuration is accepted; a strobe while busy also counts as an error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (state == CONFIG) begin
      err_q <= param_bad || para_we;
    end else if (para_we && state != IDLE) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer: image-level window model, scoreboard and stall checks.
module tb_conv_window_buffer;

  localparam int N_ROW   = 3;
  localparam int N_LANE  = 4;
  localparam int B_PIXEL = 16;
  localparam int W       = N_LANE * B_PIXEL;
  localparam int WIN_W   = W * N_ROW;
  localparam int MAX_R   = 10;
  localparam int MAX_L   = 512;

`ifdef CONV_WIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [WIN_W-1:0] LIT_WIN0 =
    192'h0003_0103_0203_0002_0102_0202_0001_0101_0201_0000_0100_0200;
  localparam logic [WIN_W-1:0] LIT_WIN3 =
    192'h0033_0133_0233_0032_0132_0232_0031_0131_0231_0030_0130_0230;

  logic        clk = 1'b0;
  logic        rstn;
  logic        para_we;
  logic [31:0] para_di;
  logic        busy;
  logic        err;

  conv_window_buffer_if #(.N_ROW(N_ROW), .N_LANE(N_LANE), .B_PIXEL(B_PIXEL)) bus ();

  conv_window_buffer #(
    .N_BUF(5), .N_ROW(N_ROW), .N_LANE(N_LANE), .B_PIXEL(B_PIXEL), .B_ADDR(9)
  ) dut (
    .clk(clk), .rstn(rstn), .para_we(para_we), .para_di(para_di),
    .busy(busy), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [W-1:0]     img [MAX_R][MAX_L];
  logic [WIN_W-1:0] exp_q [$];
  int               win_cnt;
  int               first_valid_cyc;
  int               row_done_cyc;
  int               rd_mode;
  logic [WIN_W-1:0] first_win;
  bit               prev_stall;
  logic [WIN_W-1:0] prev_data;
  logic             prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // rd_ready policy: 0 = hold off, 1 = always ready, 2 = coin flip each cycle.
  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       bus.rd_ready = 1'b0;
        1:       bus.rd_ready = 1'b1;
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [WIN_W-1:0] expw;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_output("stall_hold", 256'({bus.rd_valid, bus.rd_last, bus.rd_data}),
                       256'({1'b1, prev_last, prev_data}));
        end
        if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL extra_window: got %0h, expected no window", bus.rd_data);
          end else begin
            expw = exp_q.pop_front();
            check_output("window_data", 256'(bus.rd_data), 256'(expw));
            check_output("window_last", 256'(bus.rd_last), 256'(exp_q.size() == 0));
            win_cnt++;
            if (win_cnt == 1) first_win = bus.rd_data;
          end
        end
        prev_stall = bus.rd_valid && !bus.rd_ready;
        prev_data  = bus.rd_data;
        prev_last  = bus.rd_last;
      end
    end
  end

  task automatic fill_image(input int L, input int R, input bit ramp);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < L; c++)
        for (int j = 0; j < N_LANE; j++)
          img[r][c][j*B_PIXEL +: B_PIXEL] = ramp ? 16'(r*256 + c*16 + j) : 16'($urandom);
  endtask

  // Window (r,c): per lane, rows r..r+N_ROW-1 top to bottom, top row most significant.
  task automatic build_expected(input int L, input int R);
    exp_q.delete();
    for (int r = 0; r <= R - N_ROW; r++) begin
      for (int c = 0; c < L; c++) begin
        logic [WIN_W-1:0] w;
        w = '0;
        for (int j = N_LANE - 1; j >= 0; j--) begin
          logic [N_ROW*B_PIXEL-1:0] lane;
          lane = '0;
          for (int k = 0; k < N_ROW; k++)
            lane = {lane[(N_ROW-1)*B_PIXEL-1:0], img[r+k][c][j*B_PIXEL +: B_PIXEL]};
          w = {w[WIN_W-N_ROW*B_PIXEL-1:0], lane};
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic prep_layer(input int L, input int R, input bit ramp);
    fill_image(L, R, ramp);
    build_expected(L, R);
    win_cnt         = 0;
    first_valid_cyc = -1;
    row_done_cyc    = -1;
  endtask

  task automatic apply_stimulus(input int L, input int R);
    @(posedge clk);
    #1;
    para_di = {16'(R), 16'(L)};
    para_we = 1'b1;
    @(posedge clk);
    #1;
    para_we = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d, input int bound, output bit ok, output int fire_c);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    ok           = 1'b0;
    fire_c       = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      fire_c = cyc + 1;
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
    end
  endtask

  task automatic write_words(input int L, input int first, input int last_excl, input bit gaps);
    bit ok;
    int fc;
    for (int idx = first; idx < last_excl; idx++) begin
      int r;
      int c;
      r = idx / L;
      c = idx % L;
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      write_word(img[r][c], 3000, ok, fc);
      if (!ok) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL write_timeout: word %0d not accepted, wr_ready stayed %0b", idx, bus.wr_ready);
        return;
      end
      if (r == N_ROW - 1 && c == L - 1) row_done_cyc = fc;
    end
  endtask

  task automatic finish_layer(input int total);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready && bus.rd_last) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL layer_timeout: got %0d windows, expected %0d with rd_last", win_cnt, total);
    end else begin
      check_output("busy_at_last", 256'(busy), 256'(1));
      @(negedge clk);
      check_output("busy_drop", 256'(busy), 256'(0));
    end
    check_output("window_count", 256'(win_cnt), 256'(total));
    check_output("first_latency", 256'(first_valid_cyc), 256'(row_done_cyc + 2));
    @(posedge clk);
    #1;
  endtask

  task automatic config_illegal(input int L, input int R);
    apply_stimulus(L, R);
    @(negedge clk);
    check_output("illegal_config_state", 256'({busy, bus.wr_ready}), 256'(2'b10));
    @(negedge clk);
    check_output("illegal_back_idle", 256'({busy, bus.wr_ready}), 256'(2'b00));
    check_output("illegal_err", 256'(err), 256'(ERR_EN));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int fc;
    rstn            = 1'b0;
    para_we         = 1'b0;
    para_di         = '0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    rd_mode         = 1;
    win_cnt         = 0;
    first_valid_cyc = -1;
    row_done_cyc    = -1;
    #12;
    check_output("reset_outputs", 256'({bus.wr_ready, bus.rd_valid, bus.rd_last, busy, err}), 256'(0));
    check_output("reset_rd_data", 256'(bus.rd_data), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Ramp layer L=4 R=3, always ready.
    prep_layer(4, 3, 1'b1);
    check_output("model_win0", 256'(exp_q[0]), 256'(LIT_WIN0));
    check_output("model_win3", 256'(exp_q[3]), 256'(LIT_WIN3));
    rd_mode = 1;
    apply_stimulus(4, 3);
    write_words(4, 0, 12, 1'b0);
    finish_layer(4);
    check_output("dut_win0_literal", 256'(first_win), 256'(LIT_WIN0));

    // L=8 R=10 with reader held off: buffer fills to five rows, then drains.
    prep_layer(8, 10, 1'b0);
    rd_mode = 0;
    apply_stimulus(8, 10);
    write_words(8, 0, 40, 1'b0);
    write_word(img[5][0], 20, ok, fc);
    check_output("wr_ready_full", 256'(ok), 256'(0));
    check_output("wr_ready_low", 256'(bus.wr_ready), 256'(0));
    check_output("no_accept_stalled", 256'(win_cnt), 256'(0));
    rd_mode = 1;
    write_words(8, 40, 80, 1'b0);
    finish_layer(64);

    // L=16 R=6, random ready and write gaps, stray para_we mid-layer.
    prep_layer(16, 6, 1'b0);
    rd_mode = 2;
    apply_stimulus(16, 6);
    write_words(16, 0, 40, 1'b1);
    para_di = 32'h0003_0004;
    para_we = 1'b1;
    @(posedge clk);
    #1;
    para_we = 1'b0;
    @(negedge clk);
    check_output("busy_ignore_we", 256'(busy), 256'(1));
    @(posedge clk);
    #1;
    write_words(16, 40, 96, 1'b1);
    finish_layer(64);
    check_output("err_after_stray_we", 256'(err), 256'(ERR_EN));

    // Illegal parameter sets, then the largest legal row length.
    config_illegal(0, 5);
    config_illegal(4, 2);
    config_illegal(513, 3);
    prep_layer(512, 3, 1'b0);
    rd_mode = 1;
    apply_stimulus(512, 3);
    write_words(512, 0, 1536, 1'b0);
    check_output("err_cleared", 256'(err), 256'(0));
    finish_layer(512);

    // Abort L=8 R=5 in the middle of row 3, then a clean L=4 R=3 layer.
    prep_layer(8, 5, 1'b0);
    rd_mode = 1;
    apply_stimulus(8, 5);
    write_words(8, 0, 28, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check_output("abort_outputs", 256'({bus.wr_ready, bus.rd_valid, bus.rd_last, busy, err}), 256'(0));
    check_output("abort_rd_data", 256'(bus.rd_data), 256'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    prep_layer(4, 3, 1'b0);
    rd_mode = 2;
    apply_stimulus(4, 3);
    write_words(4, 0, 12, 1'b0);
    finish_layer(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL have parameter N_BUF, default 5, number of row buffers (N_BUF > N_ROW).
REQ-002 SHALL have parameter N_ROW, default 3, kernel height (rows per window).
REQ-003 SHALL have parameter N_LANE, default 4, pixel lanes per word.
REQ-004 SHALL have parameter B_PIXEL, default 16, bits per pixel.
REQ-005 SHALL have parameter B_ADDR, default 9, row-buffer address width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port para_we  input  1  layer-parameter write strobe.
REQ-009 SHALL have port para_di  input  32  [15:0] row length L in words, [31:16] image rows R.
REQ-010 SHALL have ports wr_valid input 1 / wr_ready output 1 / wr_data input N_LANE*B_PIXEL for the row-word write stream.
REQ-011 SHALL have ports rd_valid output 1 / rd_ready input 1 / rd_data output N_LANE*N_ROW*B_PIXEL for the window stream.
REQ-012 SHALL have ports rd_last output 1 (final window of layer), busy output 1 (state != IDLE), err output 1 (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE -> CONFIG (para_we in IDLE) -> RUN (next cycle) -> IDLE (window with rd_last accepted).
REQ-014 SHALL latch para_di in CONFIG; para_we outside IDLE is ignored.
REQ-015 SHALL treat L==0, L>2^B_ADDR or R<N_ROW as illegal: CONFIG returns to IDLE, no transfer.
REQ-016 SHALL accept a write word when wr_valid && wr_ready; wr_ready = RUN && rows_written<R && occupancy<N_BUF.
REQ-017 SHALL store words of a row sequentially from address 0 in buffer wr_sel; after L words wr_sel advances mod N_BUF and rows_written increments.
REQ-018 SHALL define occupancy = rows_written - rows_retired (completed rows only); simultaneous row completion and retirement leaves it unchanged.
REQ-019 SHALL produce windows when occupancy >= N_ROW: column c, lane j = {buf[rd_base][c].lane j, buf[rd_base+1][c].lane j, ..., buf[rd_base+N_ROW-1][c].lane j}, indices mod N_BUF, lane 0 in LSBs, rd_base row most significant.
REQ-020 SHALL advance c per accepted window; after column L-1, rd_base += 1 mod N_BUF, rows_retired += 1, c = 0 (vertical stride 1).
REQ-021 SHALL emit R-N_ROW+1 output rows of L windows; rd_last high only with the final window.
REQ-022 SHALL hold rd_data/rd_valid/rd_last stable while rd_valid && !rd_ready (no drop, no duplicate).
REQ-023 SHALL present first rd_valid exactly 2 cycles after the write completing row N_ROW-1 (1 BRAM + 1 output register), sustaining 1 window/cycle with rd_ready high.

Reset
REQ-024 SHALL, on rstn low, asynchronously clear FSM to IDLE, all counters/pointers/latched parameters to 0, rd_valid/rd_last/busy/err to 0, wr_ready to 0; RAM contents undefined.
REQ-025 SHALL abort any layer when rstn asserts mid-operation; first post-reset para_we starts cleanly.

Configuration
REQ-026 SHALL, with CONV_WIN_ERR_EN defined, drive err as sticky flag set by illegal parameters or para_we outside IDLE, cleared by next legal para_we in IDLE.
REQ-027 SHALL, without CONV_WIN_ERR_EN, tie err to 0 and include no error logic; all other behaviour identical.

Verification
REQ-028 SHALL test L=4, R=3, N_ROW=3, rows of ramp data, rd_ready=1 -> exactly 4 windows, rd_last on 4th, busy drops next cycle.
REQ-029 SHALL test L=8, R=10, rd_ready=0 -> wr_ready drops after 5 full rows (occupancy 5); releasing rd_ready -> 64 windows, in order, correct mod-5 wrap.
REQ-030 SHALL test random rd_ready toggling (50%) with L=16, R=6 -> 64 windows match golden model, rd_data stable during stalls.
REQ-031 SHALL test para_di L=0 or R=2 -> FSM back to IDLE in 2 cycles, no wr_ready; err=1 only with CONV_WIN_ERR_EN.
REQ-032 SHALL test rstn low mid-row-3 of L=8, R=5 -> all outputs 0 immediately; new layer L=4, R=3 completes with 4 correct windows.
